// File: rtl/apb2axi_tag_dir.sv
// apb2axi_tag_dir: free-list request directory with in-order issue FIFO and out-of-order completion.
// Define APB2AXI_DIR_TIMEOUT_EN to add a per-entry issue-to-completion timeout.
package apb2axi_tag_dir_pkg;
  localparam int TAG_NUM = 8;
  localparam int TAG_W = $clog2(TAG_NUM);
  localparam int AXI_ADDR_W = 32;
  localparam int TAG_FIELD_W = 8;
  typedef enum logic [2:0] {ST_EMPTY, ST_PENDING, ST_ISSUED, ST_DONE, ST_ERROR} dir_state_e;
  typedef struct packed {
    dir_state_e             state;
    logic [AXI_ADDR_W-1:0]  addr;
    logic [7:0]             len;
    logic [2:0]             size;
    logic                   is_write;
    logic [1:0]             burst;
    logic [TAG_FIELD_W-1:0] tag;
  } directory_entry_t;
endpackage

module apb2axi_tag_dir
  import apb2axi_tag_dir_pkg::*;
#(
  parameter int TAG_NUM_P = TAG_NUM,
  parameter int TAG_W_P   = $clog2(TAG_NUM_P),
  parameter int TIMEOUT_P = 1024
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic                  commit_pulse,
  input  logic [AXI_ADDR_W-1:0] addr,
  input  logic [7:0]            len,
  input  logic [2:0]            size,
  input  logic                  is_write,
  output logic                  commit_ready,
  output logic [TAG_W_P-1:0]    commit_tag,
  output logic                  pending_valid,
  output directory_entry_t      pending_entry,
  output logic [TAG_W_P-1:0]    pending_tag,
  input  logic                  pending_pop,
  input  logic                  cpl_valid,
  input  logic [TAG_W_P-1:0]    cpl_tag,
  input  logic                  cpl_error,
  input  logic                  retire_valid,
  input  logic [TAG_W_P-1:0]    retire_tag,
  input  logic [TAG_W_P-1:0]    stat_tag,
  output dir_state_e            stat_state,
  output logic [TAG_W_P:0]      free_count,
  output logic                  overflow_err
);
  directory_entry_t entries_q [TAG_NUM_P];
  directory_entry_t entries_d [TAG_NUM_P];
  logic [TAG_W_P-1:0] fifo_q [TAG_NUM_P];
  logic [TAG_W_P-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [TAG_W_P:0] cnt_q, cnt_d, free_q, free_d;
  logic ovf_q;
  logic commit, pop, cpl_hit, retire_hit;
  logic [TAG_NUM_P-1:0] tmo_hit;

  if (TAG_NUM_P != (1 << TAG_W_P) || TAG_W_P < 1 || TAG_W_P > TAG_FIELD_W || TIMEOUT_P < 2) begin : g_param_chk
    $error("apb2axi_tag_dir: illegal parameter set");
  end

  always_comb begin
    commit_tag = '0;
    commit_ready = 1'b0;
    for (int i = TAG_NUM_P - 1; i >= 0; i--)
      if (entries_q[i].state == ST_EMPTY) begin
        commit_tag = TAG_W_P'(i);
        commit_ready = 1'b1;
      end
  end

  assign commit        = commit_pulse & commit_ready;
  assign pending_valid = cnt_q != '0;
  assign pending_tag   = fifo_q[rd_q];
  assign pending_entry = entries_q[pending_tag];
  assign pop           = pending_pop & pending_valid;
  assign cpl_hit       = cpl_valid && entries_q[cpl_tag].state == ST_ISSUED;
  assign retire_hit    = retire_valid && (entries_q[retire_tag].state inside {ST_DONE, ST_ERROR});
  assign stat_state    = entries_q[stat_tag].state;
  assign free_count    = free_q;
  assign overflow_err  = ovf_q;
  assign rd_d          = rd_q + TAG_W_P'(pop);
  assign wr_d          = wr_q + TAG_W_P'(commit);
  assign cnt_d         = cnt_q + (TAG_W_P+1)'(commit) - (TAG_W_P+1)'(pop);
  assign free_d        = free_q - (TAG_W_P+1)'(commit) + (TAG_W_P+1)'(retire_hit);

  // Events on one tag are mutually exclusive by state; completion is applied after timeout so it wins.
  always_comb begin
    entries_d = entries_q;
    for (int i = 0; i < TAG_NUM_P; i++)
      if (tmo_hit[i]) entries_d[i].state = ST_ERROR;
    if (commit) begin
      entries_d[commit_tag].state    = ST_PENDING;
      entries_d[commit_tag].addr     = addr;
      entries_d[commit_tag].len      = len;
      entries_d[commit_tag].size     = size;
      entries_d[commit_tag].is_write = is_write;
      entries_d[commit_tag].burst    = 2'b01;
      entries_d[commit_tag].tag      = TAG_FIELD_W'(commit_tag);
    end
    if (pop) entries_d[pending_tag].state = ST_ISSUED;
    if (cpl_hit) entries_d[cpl_tag].state = cpl_error ? ST_ERROR : ST_DONE;
    if (retire_hit) entries_d[retire_tag].state = ST_EMPTY;
  end

`ifdef APB2AXI_DIR_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_P);
  logic [TMO_W-1:0] tmo_q [TAG_NUM_P];
  logic [TMO_W-1:0] tmo_d [TAG_NUM_P];

  always_comb begin
    for (int i = 0; i < TAG_NUM_P; i++) begin
      tmo_d[i] = (pop && pending_tag == TAG_W_P'(i)) ? '0 :
                 entries_q[i].state == ST_ISSUED ? tmo_q[i] + TMO_W'(1) : tmo_q[i];
      tmo_hit[i] = entries_q[i].state == ST_ISSUED && tmo_q[i] == TMO_W'(TIMEOUT_P - 1);
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      for (int i = 0; i < TAG_NUM_P; i++) tmo_q[i] <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  assign tmo_hit = '0;
`endif

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      for (int i = 0; i < TAG_NUM_P; i++) begin
        entries_q[i] <= '{state: ST_EMPTY, addr: '0, len: '0, size: '0, is_write: 1'b0,
                          burst: 2'b01, tag: TAG_FIELD_W'(i)};
        fifo_q[i] <= '0;
      end
      rd_q   <= '0;
      wr_q   <= '0;
      cnt_q  <= '0;
      free_q <= (TAG_W_P+1)'(TAG_NUM_P);
      ovf_q  <= 1'b0;
    end else begin
      entries_q <= entries_d;
      if (commit) fifo_q[wr_q] <= commit_tag;
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      cnt_q  <= cnt_d;
      free_q <= free_d;
      ovf_q  <= ovf_q | (commit_pulse & ~commit_ready);
    end
  end
endmodule

// File: tb/tb_apb2axi_tag_dir.sv
// tb_apb2axi_tag_dir: directed vector table, hand-written corner sequences and a randomized run
// checked against a queue/array reference model.
module tb_apb2axi_tag_dir;
  import apb2axi_tag_dir_pkg::*;
  localparam int N = 8;
  localparam int TW = 3;
  localparam int TMO = 16;
  localparam int E = 0, P = 1, I = 2, D = 3, R = 4;

  logic pclk = 1'b0;
  logic presetn;
  logic commit_pulse, is_write, pending_pop, cpl_valid, cpl_error, retire_valid;
  logic [AXI_ADDR_W-1:0] addr;
  logic [7:0] len;
  logic [2:0] size;
  logic [TW-1:0] cpl_tag, retire_tag, stat_tag, commit_tag, pending_tag;
  logic commit_ready, pending_valid, overflow_err;
  directory_entry_t pending_entry;
  dir_state_e stat_state;
  logic [TW:0] free_count;

  int n_chk = 0, n_fail = 0;

  int m_st[N];
  logic [31:0] m_addr[N];
  int m_pop_edge[N];
  int m_q[$];
  bit m_ovf;
  int edge_cnt;

  typedef struct {
    bit cm; logic [31:0] addr; bit pop; bit cpl; int ctg; bit cer; bit ret; int rtg; int stg;
    bit rdy; int ctag; bit pv; int ptag; logic [31:0] paddr; int st; int fc; bit ovf;
  } vec_t;
  vec_t vecs[$];

  always #5 pclk = ~pclk;

  apb2axi_tag_dir #(.TAG_NUM_P(N), .TAG_W_P(TW), .TIMEOUT_P(TMO)) dut (
    .pclk(pclk), .presetn(presetn), .commit_pulse(commit_pulse), .addr(addr), .len(len),
    .size(size), .is_write(is_write), .commit_ready(commit_ready), .commit_tag(commit_tag),
    .pending_valid(pending_valid), .pending_entry(pending_entry), .pending_tag(pending_tag),
    .pending_pop(pending_pop), .cpl_valid(cpl_valid), .cpl_tag(cpl_tag), .cpl_error(cpl_error),
    .retire_valid(retire_valid), .retire_tag(retire_tag), .stat_tag(stat_tag),
    .stat_state(stat_state), .free_count(free_count), .overflow_err(overflow_err)
  );

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drv(bit cm, logic [31:0] a, bit pp, bit cv, int ct, bit ce, bit rv, int rt, int st);
    commit_pulse = cm;
    addr = a;
    len = a[19:12];
    size = 3'd2;
    is_write = a[12];
    pending_pop = pp;
    cpl_valid = cv;
    cpl_tag = TW'(ct);
    cpl_error = ce;
    retire_valid = rv;
    retire_tag = TW'(rt);
    stat_tag = TW'(st);
  endtask

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  function automatic vec_t mk(bit cm, logic [31:0] a, bit pp, bit cv, int ct, bit ce, bit rv, int rt,
                              int st, bit rdy, int ctag, bit pv, int ptag, logic [31:0] paddr,
                              int sst, int fc, bit ovf);
    vec_t v;
    v = '{cm, a, pp, cv, ct, ce, rv, rt, st, rdy, ctag, pv, ptag, paddr, sst, fc, ovf};
    return v;
  endfunction

  function automatic int lowest_empty();
    for (int t = 0; t < N; t++) if (m_st[t] == E) return t;
    return -1;
  endfunction

  task automatic model_reset();
    for (int t = 0; t < N; t++) begin
      m_st[t] = E;
      m_addr[t] = '0;
      m_pop_edge[t] = 0;
    end
    m_q.delete();
    m_ovf = 0;
    edge_cnt = 0;
  endtask

  // Advances the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    int ns[N];
    int ce;
    bit do_commit, do_pop;
    ns = m_st;
    ce = lowest_empty();
    do_commit = commit_pulse && ce >= 0;
    if (commit_pulse && ce < 0) m_ovf = 1;
    do_pop = pending_pop && m_q.size() > 0;
`ifdef APB2AXI_DIR_TIMEOUT_EN
    for (int t = 0; t < N; t++)
      if (m_st[t] == I && edge_cnt - m_pop_edge[t] == TMO) ns[t] = R;
`endif
    if (do_commit) begin
      ns[ce] = P;
      m_addr[ce] = addr;
    end
    if (do_pop) begin
      ns[m_q[0]] = I;
      m_pop_edge[m_q[0]] = edge_cnt;
      void'(m_q.pop_front());
    end
    if (cpl_valid && m_st[cpl_tag] == I) ns[cpl_tag] = cpl_error ? R : D;
    if (retire_valid && (m_st[retire_tag] == D || m_st[retire_tag] == R)) ns[retire_tag] = E;
    if (do_commit) m_q.push_back(ce);
    m_st = ns;
    edge_cnt++;
  endtask

  task automatic model_compare(int c);
    int le, fc;
    le = lowest_empty();
    fc = 0;
    for (int t = 0; t < N; t++) if (m_st[t] == E) fc++;
    chk($sformatf("rnd%0d commit_ready", c), 32'(commit_ready), 32'(le >= 0));
    if (le >= 0) chk($sformatf("rnd%0d commit_tag", c), 32'(commit_tag), 32'(le));
    chk($sformatf("rnd%0d pending_valid", c), 32'(pending_valid), 32'(m_q.size() > 0));
    if (m_q.size() > 0) begin
      chk($sformatf("rnd%0d pending_tag", c), 32'(pending_tag), 32'(m_q[0]));
      chk($sformatf("rnd%0d pending_addr", c), pending_entry.addr, m_addr[m_q[0]]);
      chk($sformatf("rnd%0d pending_len", c), 32'(pending_entry.len), 32'(m_addr[m_q[0]][19:12]));
      chk($sformatf("rnd%0d pending_state", c), 32'(pending_entry.state), 32'(P));
    end
    chk($sformatf("rnd%0d stat_state[%0d]", c, stat_tag), 32'(stat_state), 32'(m_st[stat_tag]));
    chk($sformatf("rnd%0d free_count", c), 32'(free_count), 32'(fc));
    chk($sformatf("rnd%0d overflow_err", c), 32'(overflow_err), 32'(m_ovf));
  endtask

  initial begin
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    presetn = 1'b1;
    #1 presetn = 1'b0;
    #1;
    chk("rst commit_ready", 32'(commit_ready), 1);
    chk("rst commit_tag", 32'(commit_tag), 0);
    chk("rst pending_valid", 32'(pending_valid), 0);
    chk("rst pending_tag", 32'(pending_tag), 0);
    chk("rst entry0 burst", 32'(pending_entry.burst), 1);
    chk("rst entry0 addr", pending_entry.addr, 0);
    chk("rst free_count", 32'(free_count), N);
    chk("rst overflow_err", 32'(overflow_err), 0);
    chk("rst stat_state", 32'(stat_state), E);
    repeat (2) @(posedge pclk);
    @(negedge pclk) presetn = 1'b1;

    //          cm addr     pp cv ct ce rv rt st   rdy ctag pv ptag paddr   st fc ovf
    vecs.push_back(mk(1, 'h1000, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 'h1000, P, 7, 0));
    vecs.push_back(mk(1, 'h2000, 0, 0, 0, 0, 0, 0, 1, 1, 2, 1, 0, 'h1000, P, 6, 0));
    vecs.push_back(mk(1, 'h3000, 0, 0, 0, 0, 0, 0, 2, 1, 3, 1, 0, 'h1000, P, 5, 0));
    vecs.push_back(mk(1, 'h4000, 0, 0, 0, 0, 0, 0, 3, 1, 4, 1, 0, 'h1000, P, 4, 0));
    vecs.push_back(mk(1, 'h5000, 0, 0, 0, 0, 0, 0, 4, 1, 5, 1, 0, 'h1000, P, 3, 0));
    vecs.push_back(mk(1, 'h6000, 0, 0, 0, 0, 0, 0, 5, 1, 6, 1, 0, 'h1000, P, 2, 0));
    vecs.push_back(mk(1, 'h7000, 0, 0, 0, 0, 0, 0, 6, 1, 7, 1, 0, 'h1000, P, 1, 0));
    vecs.push_back(mk(1, 'h8000, 0, 0, 0, 0, 0, 0, 7, 0, 0, 1, 0, 'h1000, P, 0, 0));
    vecs.push_back(mk(1, 'h9000, 0, 0, 0, 0, 0, 0, 7, 0, 0, 1, 0, 'h1000, P, 0, 1));
    vecs.push_back(mk(0, 0,      1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 'h2000, I, 0, 1));
    vecs.push_back(mk(0, 0,      1, 0, 0, 0, 0, 0, 1, 0, 0, 1, 2, 'h3000, I, 0, 1));
    vecs.push_back(mk(0, 0,      1, 0, 0, 0, 0, 0, 2, 0, 0, 1, 3, 'h4000, I, 0, 1));
    vecs.push_back(mk(0, 0,      0, 1, 2, 0, 0, 0, 2, 0, 0, 1, 3, 'h4000, D, 0, 1));
    vecs.push_back(mk(0, 0,      0, 1, 0, 1, 0, 0, 0, 0, 0, 1, 3, 'h4000, R, 0, 1));
    vecs.push_back(mk(0, 0,      0, 1, 1, 0, 0, 0, 1, 0, 0, 1, 3, 'h4000, D, 0, 1));
    vecs.push_back(mk(0, 0,      0, 1, 3, 0, 0, 0, 3, 0, 0, 1, 3, 'h4000, P, 0, 1));
    vecs.push_back(mk(0, 0,      1, 0, 0, 0, 0, 0, 3, 0, 0, 1, 4, 'h5000, I, 0, 1));
    vecs.push_back(mk(0, 0,      0, 0, 0, 0, 1, 3, 3, 0, 0, 1, 4, 'h5000, I, 0, 1));
    vecs.push_back(mk(0, 0,      0, 0, 0, 0, 1, 0, 0, 1, 0, 1, 4, 'h5000, E, 1, 1));
    vecs.push_back(mk(1, 'hA000, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 4, 'h5000, E, 1, 1));
    vecs.push_back(mk(1, 'hB000, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 4, 'h5000, P, 0, 1));
    vecs.push_back(mk(0, 0,      0, 0, 0, 0, 1, 2, 2, 1, 2, 1, 4, 'h5000, E, 1, 1));
    vecs.push_back(mk(1, 'hC000, 1, 1, 3, 1, 0, 0, 3, 0, 0, 1, 5, 'h6000, R, 0, 1));
    vecs.push_back(mk(0, 0,      0, 0, 0, 0, 1, 3, 4, 1, 3, 1, 5, 'h6000, I, 1, 1));

    foreach (vecs[k]) begin
      drv(vecs[k].cm, vecs[k].addr, vecs[k].pop, vecs[k].cpl, vecs[k].ctg, vecs[k].cer,
          vecs[k].ret, vecs[k].rtg, vecs[k].stg);
      step();
      chk($sformatf("v%0d commit_ready", k), 32'(commit_ready), 32'(vecs[k].rdy));
      if (vecs[k].rdy) chk($sformatf("v%0d commit_tag", k), 32'(commit_tag), 32'(vecs[k].ctag));
      chk($sformatf("v%0d pending_valid", k), 32'(pending_valid), 32'(vecs[k].pv));
      chk($sformatf("v%0d pending_tag", k), 32'(pending_tag), 32'(vecs[k].ptag));
      chk($sformatf("v%0d pending_addr", k), pending_entry.addr, vecs[k].paddr);
      chk($sformatf("v%0d pending_len", k), 32'(pending_entry.len), 32'(vecs[k].paddr[19:12]));
      chk($sformatf("v%0d pending_wr", k), 32'(pending_entry.is_write), 32'(vecs[k].paddr[12]));
      chk($sformatf("v%0d pending_burst", k), 32'(pending_entry.burst), 1);
      chk($sformatf("v%0d pending_etag", k), 32'(pending_entry.tag), 32'(vecs[k].ptag));
      chk($sformatf("v%0d stat_state", k), 32'(stat_state), 32'(vecs[k].st));
      chk($sformatf("v%0d free_count", k), 32'(free_count), 32'(vecs[k].fc));
      chk($sformatf("v%0d overflow_err", k), 32'(overflow_err), 32'(vecs[k].ovf));
    end

    // Asynchronous reset mid-operation, then a stale completion for a formerly issued tag.
    drv(0, 0, 0, 0, 0, 0, 0, 0, 4);
    #2 presetn = 1'b0;
    #1;
    chk("mid-rst free_count", 32'(free_count), N);
    chk("mid-rst pending_valid", 32'(pending_valid), 0);
    chk("mid-rst overflow_err", 32'(overflow_err), 0);
    chk("mid-rst commit_tag", 32'(commit_tag), 0);
    chk("mid-rst stat_state", 32'(stat_state), E);
    @(negedge pclk) presetn = 1'b1;
    drv(0, 0, 0, 1, 4, 0, 0, 0, 4);
    step();
    chk("stale cpl ignored", 32'(stat_state), E);

`ifdef APB2AXI_DIR_TIMEOUT_EN
    drv(1, 'hD000, 0, 0, 0, 0, 0, 0, 0);
    step();
    drv(0, 0, 1, 0, 0, 0, 0, 0, 0);
    step();
    chk("tmo popped", 32'(stat_state), I);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (TMO - 1) step();
    chk("tmo before limit", 32'(stat_state), I);
    step();
    chk("tmo fired", 32'(stat_state), R);
    drv(1, 'hE000, 0, 0, 0, 0, 0, 0, 1);
    step();
    drv(0, 0, 1, 0, 0, 0, 0, 0, 1);
    step();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 1);
    repeat (TMO - 1) step();
    chk("tmo cpl pre", 32'(stat_state), I);
    drv(0, 0, 0, 1, 1, 0, 0, 0, 1);
    step();
    chk("tmo cpl priority", 32'(stat_state), D);
    drv(0, 0, 0, 1, 0, 0, 0, 0, 0);
    step();
    chk("tmo late cpl ignored", 32'(stat_state), R);
`endif

    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge pclk) presetn = 1'b0;
    @(negedge pclk) presetn = 1'b1;
    model_reset();
    for (int c = 0; c < 800; c++) begin
      drv($urandom_range(0, 1), $urandom, $urandom_range(0, 1), $urandom_range(0, 9) < 6,
          $urandom_range(0, N - 1), $urandom_range(0, 1), $urandom_range(0, 1),
          $urandom_range(0, N - 1), $urandom_range(0, N - 1));
      model_edge();
      step();
      model_compare(c);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/apb2axi_tag_dir.md
# apb2axi_tag_dir

Parametrised successor to the gateway request directory. It allocates tags from a free list rather than a wrapping pointer, and it back-pressures the APB register file when every tag is in use. Requests are issued to the transaction manager in commit order through an internal tag FIFO, and they complete out of order. Each entry is held in DONE/ERROR until software retires it, which makes completion status readable over APB.

## Interface
Parameters:
- TAG_NUM_P, default TAG_NUM: number of directory entries (power of two, 2..256).
- TAG_W_P, default TAG_W: tag width, $clog2(TAG_NUM_P).
- TIMEOUT_P, default 1024: issue-to-completion timeout in cycles (used only with APB2AXI_DIR_TIMEOUT_EN).

Ports:
- pclk  in  1  clock.
- presetn  in  1  asynchronous active-low reset.
- commit_pulse  in  1  register file commits one request.
- addr  in  AXI_ADDR_W  request address.
- len  in  8  AXI burst length.
- size  in  3  AXI burst size.
- is_write  in  1  1 = write request.
- commit_ready  out  1  a free entry exists.
- commit_tag  out  TAG_W_P  tag the next commit will receive.
- pending_valid  out  1  the head of the issue FIFO is PENDING.
- pending_entry  out  directory_entry_t  entry at the FIFO head.
- pending_tag  out  TAG_W_P  tag at the FIFO head.
- pending_pop  in  1  the transaction manager accepts the head.
- cpl_valid  in  1  completion strobe.
- cpl_tag  in  TAG_W_P  completing tag.
- cpl_error  in  1  completion carried an error response.
- retire_valid  in  1  software releases an entry.
- retire_tag  in  TAG_W_P  tag to release.
- stat_tag  in  TAG_W_P  status query index.
- stat_state  out  state field of directory_entry_t  combinational state of entry stat_tag.
- free_count  out  TAG_W_P+1  number of EMPTY entries.
- overflow_err  out  1  sticky: a commit arrived while commit_ready was 0.

## Operation
- Entry states: EMPTY -> PENDING (commit) -> ISSUED (pop) -> DONE or ERROR (completion or timeout) -> EMPTY (retire).
- Allocation: commit_tag is the lowest-index EMPTY entry, taken from the pre-edge state. A commit writes addr, len, size, is_write, burst = 2'b01 and tag into that entry, and pushes the tag into the issue FIFO.
- If commit_pulse arrives while commit_ready = 0:
  - the request is dropped;
  - overflow_err is set and stays set until reset;
  - no state changes.
- Issue FIFO:
  - depth TAG_NUM_P;
  - it cannot overflow, because every entry in it is a distinct tag;
  - pending_valid = FIFO non-empty.
- pending_pop when pending_valid = 0 is ignored.
- Completion:
  - cpl_valid on an ISSUED entry moves it to ERROR if cpl_error = 1, otherwise to DONE;
  - cpl_valid on an entry in any other state is ignored.
- Retire:
  - retire_valid on a DONE or ERROR entry moves it to EMPTY and increments free_count;
  - retire_valid on an entry in any other state is ignored.
- Simultaneous events:
  - Commit, pop, completion and retire on different tags in the same cycle all take effect.
  - A tag retired in cycle N is not allocated until cycle N+1.
  - A commit to an empty FIFO and a pop in the same cycle: the pop is ignored (no bypass).
  - free_count reflects the net effect of commit and retire in that cycle.

## Timing
- Reset (asynchronous, presetn = 0):
  - all entries EMPTY, tag = index, other fields 0, burst = 2'b01;
  - FIFO empty; free_count = TAG_NUM_P; commit_ready = 1; commit_tag = 0;
  - pending_valid = 0; pending_tag = 0; pending_entry = entry 0; overflow_err = 0; timeout counters 0.
- Reset asserted mid-operation discards all entries. Outstanding AXI completions arriving after reset find their entries EMPTY and are ignored.
- Commit at edge N: pending_valid = 1 from cycle N+1 if the FIFO was empty. commit_tag and commit_ready update in cycle N+1.
- pending_entry, pending_tag and stat_state are combinational from the registered state.
- Pop at edge N: the entry reads ISSUED in cycle N+1.
- Completion at edge N: the entry reads DONE or ERROR in cycle N+1.

## Configuration
- APB2AXI_DIR_TIMEOUT_EN defined:
  - Each ISSUED entry runs a counter that is cleared at pop.
  - When the counter reaches TIMEOUT_P-1 while the entry is still ISSUED, the entry moves to ERROR on the next edge.
  - A cpl_valid in that same cycle takes priority, with its normal DONE/ERROR result.
  - Late completions for timed-out entries are ignored.
- APB2AXI_DIR_TIMEOUT_EN undefined: no counters are built, and ISSUED entries wait indefinitely.

## Test plan
- Reset, then 3 commits (addr 0x1000/0x2000/0x3000) -> tags 0, 1, 2; free_count = TAG_NUM_P-3; pending_tag = 0 with addr 0x1000.
- Fill all TAG_NUM_P entries, then 1 more commit -> commit_ready = 0, overflow_err = 1, FIFO contents unchanged.
- Pop tags 0, 1, 2, then complete them in order 2, 0 (cpl_error = 1), 1 -> states DONE, ERROR, DONE read back via stat_state.
- Retire tag 1 while committing in the same cycle -> the commit takes the lowest other EMPTY tag; tag 1 is reusable in the next cycle.
- cpl_valid on a PENDING tag, and retire_valid on an ISSUED tag -> both ignored; states unchanged.
- With APB2AXI_DIR_TIMEOUT_EN and TIMEOUT_P = 16: pop tag 0 with no completion -> ERROR exactly 16 cycles after the pop; a completion arriving on the timeout cycle -> DONE.
